// File: rtl/io_spi_pkg.sv
// rtl/io_spi_pkg.sv - register map, bit indices and FSM encoding for io_spi_bridge
package io_spi_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_CTRL = 2'd1;
  localparam logic [1:0] ADDR_DIV  = 2'd2;
  localparam logic [1:0] ADDR_RSVD = 2'd3;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_RX_VALID = 1;
  localparam int STAT_OVERRUN  = 2;

  localparam int CTRL_SS_HOLD = 0;
  localparam int CTRL_INT_EN  = 1;
  localparam int CTRL_CLR_OVR = 7;

  localparam logic [7:0] DIV_RESET_DEFAULT = 8'd12;

  // SHIFT phase spans 16 half-periods, numbered 1..16
  localparam logic [4:0] LAST_HALF = 5'd16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

  function automatic logic [7:0] pack_status(input logic busy, input logic rx_valid,
                                             input logic overrun);
    logic [7:0] s;
    s                = 8'h00;
    s[STAT_BUSY]     = busy;
    s[STAT_RX_VALID] = rx_valid;
    s[STAT_OVERRUN]  = overrun;
    return s;
  endfunction

endpackage

// File: rtl/spi_shifter.sv
// rtl/spi_shifter.sv - SPI mode-0 master: SCLK divider, transfer FSM, TX/RX shift registers
module spi_shifter
  import io_spi_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] tx_byte_i,
  input  logic [7:0] div_i,
  input  logic       ss_hold_i,
  input  logic       miso_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] rx_byte_o,
  output logic       ss_o,
  output logic       sclk_o,
  output logic       mosi_o
);

  spi_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] div_lat_q, div_lat_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic [4:0] half_q, half_d;
  logic       ss_q, ss_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;
  logic       tick;

  assign tick      = (cnt_q == 8'd0);
  assign busy_o    = (state_q != ST_IDLE);
  assign rx_byte_o = rx_byte_q;
  assign ss_o      = ss_q;
  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      div_lat_q <= 8'd0;
      tx_q      <= 8'd0;
      rx_q      <= 8'd0;
      rx_byte_q <= 8'd0;
      half_q    <= 5'd0;
      ss_q      <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_lat_q <= div_lat_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_byte_q <= rx_byte_d;
      half_q    <= half_d;
      ss_q      <= ss_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_lat_d = div_lat_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_byte_d = rx_byte_q;
    half_d    = half_q;
    ss_d      = ss_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    done_o    = 1'b0;

    // Every active phase lasts div+1 cycles; the reload happens on the tick that ends it
    if (state_q != ST_IDLE) begin
      cnt_d = tick ? div_lat_q : cnt_q - 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d   = ST_SETUP;
          div_lat_d = div_i;
          cnt_d     = div_i;
          tx_d      = tx_byte_i;
          rx_d      = 8'd0;
          mosi_d    = tx_byte_i[7];
          ss_d      = 1'b0;
          sclk_d    = 1'b0;
        end else if (!ss_q && !ss_hold_i) begin
          ss_d = 1'b1;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_d = ST_SHIFT;
          half_d  = 5'd1;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[6:0], miso_i};
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (half_q == LAST_HALF) begin
            state_d = ST_HOLD;
          end else begin
            half_d = half_q + 5'd1;
            if (half_q[0]) begin
              sclk_d = 1'b0;
              tx_d   = {tx_q[6:0], 1'b0};
              mosi_d = tx_q[6];
            end else begin
              sclk_d = 1'b1;
              rx_d   = {rx_q[6:0], miso_i};
            end
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          state_d   = ST_IDLE;
          done_o    = 1'b1;
          rx_byte_d = rx_q;
          if (!ss_hold_i) begin
            ss_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/io_spi_bridge.sv
// rtl/io_spi_bridge.sv - PC Card I/O-space to SPI master bridge; IO_SPI_INT_EN enables INT/int_en
module io_spi_bridge
  import io_spi_pkg::*;
#(
  parameter logic [7:0] DIV_RESET = DIV_RESET_DEFAULT
) (
  input  logic       clk_26,
  input  logic       RESET,
  input  logic [7:0] D_in,
  output logic [7:0] D_out,
  input  logic [1:0] A,
  output logic       DDIR,
  input  logic       IOWR,
  input  logic       IORD,
  input  logic       CE1,
  input  logic       REG,
  output logic       INPACK,
  output logic       SS,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO,
  output logic       INT
);

  logic       iowr_meta_q, iowr_sync_q, iowr_prev_q;
  logic       iord_meta_q, iord_sync_q, iord_prev_q;
  logic [1:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       wr_pend_q, wr_pend_d;
  logic [1:0] rd_addr_q, rd_addr_d;
  logic       rd_pend_q, rd_pend_d;
  logic [7:0] div_q, div_d;
  logic       ss_hold_q, ss_hold_d;
  logic       rx_valid_q, rx_valid_d;
  logic       overrun_q, overrun_d;

  logic       card_sel, rd_sel;
  logic       wr_rise, rd_rise, wr_commit, rd_commit, start;
  logic       busy, done;
  logic [7:0] rx_byte, rd_mux;

  assign card_sel  = ~CE1 & ~REG;
  assign wr_rise   = iowr_sync_q & ~iowr_prev_q;
  assign rd_rise   = iord_sync_q & ~iord_prev_q;
  assign wr_commit = wr_rise & wr_pend_q;
  assign rd_commit = rd_rise & rd_pend_q;
  // busy is the pre-update value, so a commit coinciding with HOLD exit is still an overrun
  assign start     = wr_commit && (wr_addr_q == ADDR_DATA) && !busy;

  always_ff @(posedge clk_26) begin
    if (RESET) begin
      iowr_meta_q <= 1'b1;
      iowr_sync_q <= 1'b1;
      iowr_prev_q <= 1'b1;
      iord_meta_q <= 1'b1;
      iord_sync_q <= 1'b1;
      iord_prev_q <= 1'b1;
      wr_addr_q   <= 2'd0;
      wr_data_q   <= 8'd0;
      wr_pend_q   <= 1'b0;
      rd_addr_q   <= 2'd0;
      rd_pend_q   <= 1'b0;
      div_q       <= DIV_RESET;
      ss_hold_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      iowr_meta_q <= IOWR;
      iowr_sync_q <= iowr_meta_q;
      iowr_prev_q <= iowr_sync_q;
      iord_meta_q <= IORD;
      iord_sync_q <= iord_meta_q;
      iord_prev_q <= iord_sync_q;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_pend_q   <= wr_pend_d;
      rd_addr_q   <= rd_addr_d;
      rd_pend_q   <= rd_pend_d;
      div_q       <= div_d;
      ss_hold_q   <= ss_hold_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  // Bus fields are re-captured every cycle of a decoded strobe; the rising edge commits the last one
  always_comb begin
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_pend_d = wr_pend_q;
    rd_addr_d = rd_addr_q;
    rd_pend_d = rd_pend_q;
    if (!iowr_sync_q && card_sel) begin
      wr_addr_d = A;
      wr_data_d = D_in;
      wr_pend_d = 1'b1;
    end else if (wr_rise) begin
      wr_pend_d = 1'b0;
    end
    if (!iord_sync_q && card_sel) begin
      rd_addr_d = A;
      rd_pend_d = 1'b1;
    end else if (rd_rise) begin
      rd_pend_d = 1'b0;
    end
  end

  always_comb begin
    div_d      = div_q;
    ss_hold_d  = ss_hold_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    if (wr_commit) begin
      case (wr_addr_q)
        ADDR_DATA: if (busy) overrun_d = 1'b1;
        ADDR_CTRL: begin
          ss_hold_d = wr_data_q[CTRL_SS_HOLD];
          if (wr_data_q[CTRL_CLR_OVR]) overrun_d = 1'b0;
        end
        ADDR_DIV:  if (!busy) div_d = wr_data_q;
        ADDR_RSVD: ;
        default:   ;
      endcase
    end
    if (rd_commit && (rd_addr_q == ADDR_DATA)) rx_valid_d = 1'b0;
    if (done) rx_valid_d = 1'b1;
  end

`ifdef IO_SPI_INT_EN
  logic int_en_q, int_en_d;

  always_comb begin
    int_en_d = int_en_q;
    if (wr_commit && (wr_addr_q == ADDR_CTRL)) int_en_d = wr_data_q[CTRL_INT_EN];
  end

  always_ff @(posedge clk_26) begin
    if (RESET) int_en_q <= 1'b0;
    else       int_en_q <= int_en_d;
  end

  assign INT = ~(int_en_q & rx_valid_q);
`else
  assign INT = 1'b1;
`endif

  // Read path is decoded straight from the pins so data is ready within the bus access time
  assign rd_sel = ~IORD & card_sel;

  always_comb begin
    rd_mux = 8'h00;
    case (A)
      ADDR_DATA: rd_mux = rx_byte;
      ADDR_CTRL: rd_mux = pack_status(busy, rx_valid_q, overrun_q);
      ADDR_DIV:  rd_mux = div_q;
      ADDR_RSVD: rd_mux = 8'h00;
      default:   rd_mux = 8'h00;
    endcase
  end

  assign D_out  = rd_sel ? rd_mux : 8'h00;
  assign DDIR   = rd_sel;
  assign INPACK = ~rd_sel;

  spi_shifter u_shifter (
    .clk_i     (clk_26),
    .rst_i     (RESET),
    .start_i   (start),
    .tx_byte_i (wr_data_q),
    .div_i     (div_q),
    .ss_hold_i (ss_hold_q),
    .miso_i    (MISO),
    .busy_o    (busy),
    .done_o    (done),
    .rx_byte_o (rx_byte),
    .ss_o      (SS),
    .sclk_o    (SCLK),
    .mosi_o    (MOSI)
  );

endmodule

// File: tb/tb_io_spi_bridge.sv
// tb/tb_io_spi_bridge.sv - self-checking bench for io_spi_bridge with a behavioural SPI/register model
module tb_io_spi_bridge;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_CTRL = 2'd1;
  localparam logic [1:0] A_DIV  = 2'd2;
  localparam logic [1:0] A_RSVD = 2'd3;

  logic       clk_26 = 1'b0;
  logic       RESET;
  logic [7:0] D_in;
  logic [7:0] D_out;
  logic [1:0] A;
  logic       DDIR;
  logic       IOWR, IORD, CE1, REG;
  logic       INPACK;
  logic       SS, SCLK, MOSI, MISO, INT;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic       loopback    = 1'b1;
  logic [7:0] miso_pat    = 8'h00;
  logic [2:0] rise_cnt    = 3'd0;
  int         sclk_pulses = 0;
  logic [7:0] mosi_byte   = 8'h00;
  int         ss_rises    = 0;
  logic       rd_ddir, rd_inpack;

  logic m_overrun = 1'b0;
  logic m_int_en  = 1'b0;

  io_spi_bridge dut (
    .clk_26 (clk_26),
    .RESET  (RESET),
    .D_in   (D_in),
    .D_out  (D_out),
    .A      (A),
    .DDIR   (DDIR),
    .IOWR   (IOWR),
    .IORD   (IORD),
    .CE1    (CE1),
    .REG    (REG),
    .INPACK (INPACK),
    .SS     (SS),
    .SCLK   (SCLK),
    .MOSI   (MOSI),
    .MISO   (MISO),
    .INT    (INT)
  );

  always #5 clk_26 = ~clk_26;

  // Slave model: either echo MOSI or present miso_pat MSB first, one bit per SCLK pulse
  assign MISO = loopback ? MOSI : miso_pat[3'd7 - rise_cnt];

  always @(posedge SCLK) begin
    sclk_pulses = sclk_pulses + 1;
    mosi_byte   = {mosi_byte[6:0], MOSI};
    rise_cnt    = rise_cnt + 3'd1;
  end

  always @(posedge SS) ss_rises = ss_rises + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic io_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk_26);
    A = a; D_in = d; CE1 = 1'b0; REG = 1'b0; IOWR = 1'b0;
    repeat (3) @(negedge clk_26);
    IOWR = 1'b1;
    repeat (3) @(negedge clk_26);
    CE1 = 1'b1; REG = 1'b1;
  endtask

  task automatic io_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk_26);
    A = a; CE1 = 1'b0; REG = 1'b0; IORD = 1'b0;
    #1;
    d = D_out; rd_ddir = DDIR; rd_inpack = INPACK;
    repeat (3) @(negedge clk_26);
    IORD = 1'b1;
    repeat (3) @(negedge clk_26);
    CE1 = 1'b1; REG = 1'b1;
  endtask

  // Sub-cycle read strobe: too short for the synchroniser, so it has no side effect
  task automatic peek(input logic [1:0] a, output logic [7:0] d);
    A = a; CE1 = 1'b0; REG = 1'b0; IORD = 1'b0;
    #1;
    d = D_out;
    IORD = 1'b1; CE1 = 1'b1; REG = 1'b1;
  endtask

  task automatic wait_idle(output int cyc);
    logic [7:0] s;
    cyc = 0;
    peek(A_CTRL, s);
    while (s[0] && cyc < 2000) begin
      cyc++;
      @(negedge clk_26);
      peek(A_CTRL, s);
    end
  endtask

  task automatic run_xfer(input logic [7:0] tx, input logic lb, input logic [7:0] pat,
                          input logic [7:0] dv);
    int         cyc;
    int         p0;
    logic [7:0] s, d, exp_rx;
    io_write(A_DIV, dv);
    loopback = lb;
    miso_pat = pat;
    exp_rx   = lb ? tx : pat;
    p0       = sclk_pulses;
    io_write(A_DATA, tx);
    wait_idle(cyc);
    check("xfer_cycles", cyc, 18 * (dv + 1));
    check("sclk_pulses", sclk_pulses - p0, 8);
    check("mosi_bits", mosi_byte, tx);
    check("sclk_idle", SCLK, 1'b0);
    peek(A_CTRL, s);
    check("status_done", s, {5'b0, m_overrun, 2'b10});
    check("int_done", INT, m_int_en ? 1'b0 : 1'b1);
    io_read(A_DATA, d);
    check("rx_byte", d, exp_rx);
    peek(A_CTRL, s);
    check("status_read", s, {5'b0, m_overrun, 2'b00});
    check("int_read", INT, 1'b1);
  endtask

  initial begin
    logic [7:0] d, t1;
    int         cyc, p0, r0;

    RESET = 1'b1; IOWR = 1'b1; IORD = 1'b1; CE1 = 1'b1; REG = 1'b1;
    A = 2'd0; D_in = 8'd0;
    repeat (4) @(negedge clk_26);
    check("rst_dout", D_out, 8'h00);
    check("rst_ddir", DDIR, 1'b0);
    check("rst_inpack", INPACK, 1'b1);
    check("rst_ss", SS, 1'b1);
    check("rst_sclk", SCLK, 1'b0);
    check("rst_mosi", MOSI, 1'b0);
    check("rst_int", INT, 1'b1);
    RESET = 1'b0;
    @(negedge clk_26);

    io_read(A_CTRL, d);
    check("rst_status", d, 8'h00);
    check("rd_ddir", rd_ddir, 1'b1);
    check("rd_inpack", rd_inpack, 1'b0);
    io_read(A_DIV, d);
    check("rst_div", d, 8'h0C);
    io_read(A_DATA, d);
    check("rst_rx", d, 8'h00);
    io_write(A_RSVD, 8'hFF);
    io_read(A_RSVD, d);
    check("rsvd_read", d, 8'h00);
    peek(A_DIV, d);
    check("rsvd_no_effect", d, 8'h0C);

    run_xfer(8'hA5, 1'b1, 8'h00, 8'd0);

    for (int i = 0; i < 6; i++) begin
      run_xfer(8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom_range(0, 3)));
    end

    // Overrun: second DATA write lands while the first byte is still shifting
    io_write(A_DIV, 8'd3);
    loopback = 1'b1;
    t1 = 8'($urandom);
    io_write(A_DATA, t1);
    io_write(A_DATA, t1 ^ 8'hFF);
    m_overrun = 1'b1;
    peek(A_CTRL, d);
    check("status_overrun_busy", d, 8'h05);
    wait_idle(cyc);
    peek(A_CTRL, d);
    check("status_overrun_done", d, 8'h06);
    check("overrun_mosi", mosi_byte, t1);
    io_read(A_DATA, d);
    check("overrun_rx_first", d, t1);
    io_write(A_CTRL, 8'h80);
    m_overrun = 1'b0;
    peek(A_CTRL, d);
    check("overrun_cleared", d, 8'h00);

    io_write(A_DATA, 8'h3C);
    io_write(A_DIV, 8'h07);
    wait_idle(cyc);
    io_read(A_DIV, d);
    check("div_busy_ignored", d, 8'h03);
    io_read(A_DATA, d);
    check("div_busy_rx", d, 8'h3C);

    io_write(A_CTRL, 8'h02);
`ifdef IO_SPI_INT_EN
    m_int_en = 1'b1;
`endif
    run_xfer(8'h5A, 1'b0, 8'hC3, 8'd1);
    io_write(A_CTRL, 8'h00);
    m_int_en = 1'b0;

    io_write(A_CTRL, 8'h01);
    r0 = ss_rises;
    run_xfer(8'h96, 1'b1, 8'h00, 8'd0);
    run_xfer(8'h1F, 1'b0, 8'hE4, 8'd0);
    check("ss_hold_no_rise", ss_rises - r0, 0);
    check("ss_hold_low", SS, 1'b0);
    io_write(A_CTRL, 8'h00);
    check("ss_release_commit", SS, 1'b0);
    @(negedge clk_26);
    check("ss_release_next", SS, 1'b1);

    // Reset in the high phase of SCLK pulse 4
    io_write(A_DIV, 8'd2);
    loopback = 1'b1;
    p0 = sclk_pulses;
    io_write(A_DATA, 8'hFF);
    cyc = 0;
    while (sclk_pulses - p0 < 4 && cyc < 1000) begin
      @(negedge clk_26);
      cyc++;
    end
    check("rst_mid_pulses", sclk_pulses - p0, 4);
    check("rst_mid_sclk_hi", SCLK, 1'b1);
    RESET = 1'b1;
    @(negedge clk_26);
    check("rst_mid_ss", SS, 1'b1);
    check("rst_mid_sclk", SCLK, 1'b0);
    RESET = 1'b0;
    peek(A_CTRL, d);
    check("rst_mid_status", d, 8'h00);
    io_read(A_DATA, d);
    check("rst_mid_rx", d, 8'h00);
    io_read(A_DIV, d);
    check("rst_mid_div", d, 8'h0C);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
